// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding, slice width and beat-count helper
package serial_add_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
   localparam int SLICE_W = 2;
   function automatic int beats(input int width);
      return width / SLICE_W;
   endfunction
endpackage

// File: rtl/add_slice2.sv
// add_slice2: combinational 2-bit ripple slice exposing its internal carry
module add_slice2 (
   input  logic [1:0] A,
   input  logic [1:0] B,
   input  logic       CI,
   output logic [1:0] S,
   output logic       CO,
   output logic       C1
);
   assign S[0] = A[0] ^ B[0] ^ CI;
   assign C1   = (A[0] & B[0]) | (CI & (A[0] ^ B[0]));
   assign S[1] = A[1] ^ B[1] ^ C1;
   assign CO   = (A[1] & B[1]) | (C1 & (A[1] ^ B[1]));
endmodule

// File: rtl/serial_add2_seq.sv
// serial_add2_seq: multi-beat adder, 2 bits per cycle with registered carry; SIGNED_OVF_EN adds OVF
import serial_add_pkg::*;
module serial_add2_seq #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             I_VALID,
   output logic             I_READY,
   input  logic [WIDTH-1:0] I0,
   input  logic [WIDTH-1:0] I1,
   input  logic             CIN,
   output logic             O_VALID,
   input  logic             O_READY,
   output logic [WIDTH-1:0] O,
   output logic             COUT
`ifdef SIGNED_OVF_EN
   ,output logic            OVF
`endif
);
   localparam int NB = beats(WIDTH);
   localparam int CW = (NB > 1) ? $clog2(NB) : 1;
   if (WIDTH < 2 || WIDTH % 2 != 0) begin : g_bad_width
      $error("serial_add2_seq: WIDTH must be even and >= 2");
   end
   state_t state, state_nx;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] a_q, b_q, o_q, o_nx;
   logic carry, cout_q, co, last;
   logic [1:0] s;
`ifdef SIGNED_OVF_EN
   logic c1, ovf_q;
   assign OVF = ovf_q;
`endif
   add_slice2 u_slice (
      .A  (a_q[1:0]),
      .B  (b_q[1:0]),
      .CI (carry),
      .S  (s),
      .CO (co),
`ifdef SIGNED_OVF_EN
      .C1 (c1)
`else
      .C1 ()
`endif
   );
   if (WIDTH == SLICE_W) begin : g_one_beat
      assign o_nx = s;
   end else begin : g_multi_beat
      assign o_nx = {s, o_q[WIDTH-1:SLICE_W]};
   end
   assign last    = cnt == CW'(NB - 1);
   assign I_READY = state == IDLE;
   assign O_VALID = state == DONE;
   assign O       = o_q;
   assign COUT    = cout_q;
   // state register
   always_ff @(posedge CLK) begin
      state <= RESET ? IDLE : state_nx;
   end
   // next state: accept in IDLE, count beats in RUN, wait for consumer in DONE
   always_comb begin
      state_nx = state;
      if (state == IDLE && I_VALID) state_nx = RUN;
      if (state == RUN && last) state_nx = DONE;
      if (state == DONE && O_READY) state_nx = IDLE;
   end
   // datapath: latch operands on accept, then shift one slice per RUN beat
   always_ff @(posedge CLK) begin
      if (RESET) begin
         a_q    <= '0;
         b_q    <= '0;
         o_q    <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
`ifdef SIGNED_OVF_EN
         ovf_q  <= 1'b0;
`endif
      end else if (state == IDLE && I_VALID) begin
         a_q   <= I0;
         b_q   <= I1;
         carry <= CIN;
         cnt   <= '0;
      end else if (state == RUN) begin
         a_q   <= a_q >> SLICE_W;
         b_q   <= b_q >> SLICE_W;
         o_q   <= o_nx;
         carry <= co;
         cnt   <= cnt + CW'(1);
         if (last) begin
            cout_q <= co;
`ifdef SIGNED_OVF_EN
            ovf_q  <= c1 ^ co;
`endif
         end
      end
   end
endmodule

// File: tb/tb_serial_add2_seq.sv
// tb_serial_add2_seq: directed self-checking bench for serial_add2_seq at WIDTH=8
module tb_serial_add2_seq;
   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       I_VALID = 1'b0;
   logic       I_READY;
   logic [7:0] I0 = '0;
   logic [7:0] I1 = '0;
   logic       CIN = 1'b0;
   logic       O_VALID;
   logic       O_READY = 1'b0;
   logic [7:0] O;
   logic       COUT;
   int checks = 0;
   int failures = 0;
`ifdef SIGNED_OVF_EN
   logic OVF;
`endif
   serial_add2_seq #(.WIDTH(8)) dut (
      .CLK     (CLK),
      .RESET   (RESET),
      .I_VALID (I_VALID),
      .I_READY (I_READY),
      .I0      (I0),
      .I1      (I1),
      .CIN     (CIN),
      .O_VALID (O_VALID),
      .O_READY (O_READY),
      .O       (O),
      .COUT    (COUT)
`ifdef SIGNED_OVF_EN
      ,.OVF    (OVF)
`endif
   );
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   // one full operation; junk inputs and an I_VALID pulse are driven while RUN to prove they are ignored
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic [7:0] eo, input logic ec, input logic eov, input int hold);
      for (int i = 0; i < 20 && !I_READY; i++) tick();
      chk("wait_iready", I_READY, 1);
      I_VALID = 1'b1;
      I0 = a;
      I1 = b;
      CIN = ci;
      tick();
      I0 = ~a;
      I1 = 8'hA5;
      CIN = ~ci;
      chk("run_iready", I_READY, 0);
      repeat (3) tick();
      chk("run_ovalid", O_VALID, 0);
      I_VALID = 1'b0;
      tick();
      chk("done_ovalid", O_VALID, 1);
      chk("done_iready", I_READY, 0);
      chk("sum", O, eo);
      chk("cout", COUT, ec);
`ifdef SIGNED_OVF_EN
      chk("ovf", OVF, eov);
`endif
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_ovalid", O_VALID, 1);
         chk("hold_iready", I_READY, 0);
         chk("hold_sum", O, eo);
         chk("hold_cout", COUT, ec);
      end
      O_READY = 1'b1;
      tick();
      O_READY = 1'b0;
      chk("idle_iready", I_READY, 1);
      chk("idle_ovalid", O_VALID, 0);
   endtask
   initial begin
      repeat (2) tick();
      RESET = 1'b0;
      chk("rst_iready", I_READY, 1);
      chk("rst_ovalid", O_VALID, 0);
      chk("rst_sum", O, 0);
      chk("rst_cout", COUT, 0);
`ifdef SIGNED_OVF_EN
      chk("rst_ovf", OVF, 0);
`endif
      run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
      run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
      run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 3);
      run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
      run_op(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
      I_VALID = 1'b1;
      I0 = 8'h12;
      I1 = 8'h34;
      CIN = 1'b0;
      tick();
      I_VALID = 1'b0;
      repeat (2) tick();
      RESET = 1'b1;
      O_READY = 1'b1;
      tick();
      RESET = 1'b0;
      O_READY = 1'b0;
      chk("abort_iready", I_READY, 1);
      chk("abort_ovalid", O_VALID, 0);
      chk("abort_sum", O, 0);
      chk("abort_cout", COUT, 0);
      repeat (5) tick();
      chk("abort_no_result", O_VALID, 0);
      run_op(8'h01, 8'h01, 1'b1, 8'h03, 1'b0, 1'b0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/serial_add2_seq.md
Name: serial_add2_seq

Overview:
- Multi-beat sequential adder for WIDTH-bit operands.
- Consumes one 2-bit ripple slice per cycle and holds the carry in a flop between beats.
- Sits downstream of the operand source and upstream of any result consumer, with valid/ready on both sides.
- Replaces a wide combinational ripple chain with a 2-bit slice plus a carry register, trading latency for area.

Parameters:
- WIDTH, 8, operand/result width in bits; must be even and >= 2. An odd value is an elaboration error.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  synchronous, active-high reset.
- I_VALID  input  1  operands and CIN valid.
- I_READY  output  1  block can accept operands.
- I0  input  WIDTH  operand A.
- I1  input  WIDTH  operand B.
- CIN  input  1  carry-in, sampled with the operands.
- O_VALID  output  1  result valid.
- O_READY  input  1  downstream accepts the result.
- O  output  WIDTH  sum, I0+I1+CIN modulo 2^WIDTH.
- COUT  output  1  carry out of bit WIDTH-1.
- OVF  output  1  signed overflow; present only with SIGNED_OVF_EN.

Behaviour:
- One clock domain, CLK. RESET is synchronous and active-high.
- FSM states: IDLE, RUN, DONE. A registered beat counter spans 0..WIDTH/2-1.
- On the reset edge: state=IDLE, O=0, COUT=0, OVF=0, carry flop=0, counter=0. O_VALID=0.
- I_READY = (state==IDLE); O_VALID = (state==DONE). Both decode from state only; no combinational path from inputs.
- IDLE:
  - On I_VALID&I_READY, latch I0 and I1 into shift registers, carry<=CIN, counter<=0, go to RUN.
  - Otherwise hold.
- RUN, each cycle:
  - The slice adds the two LSBs of each operand register plus carry.
  - The 2-bit sum shifts into the result register from the MSB end; the result register shifts right by 2.
  - Operand registers shift right by 2. carry<=slice COUT. counter++.
  - When counter==WIDTH/2-1, COUT<=slice COUT and go to DONE.
- DONE:
  - O and COUT hold stable while O_READY=0.
  - On O_READY, go to IDLE. O and COUT keep their last value; they are don't-care once O_VALID=0.
- Latency and throughput:
  - Handshake accepted at edge t gives RUN cycles t+1..t+WIDTH/2 and O_VALID high from cycle t+WIDTH/2+1.
  - Minimum op-to-op spacing is WIDTH/2+2 cycles.
- Operands and CIN are sampled only at the accept edge. Changes on I0, I1, CIN or I_VALID during RUN/DONE are ignored.
- WIDTH=2 is a single RUN beat.
- RESET asserted in RUN or DONE aborts the operation: no result is produced, and the block is in IDLE next cycle.
- RESET has priority over every handshake on the same edge.

Optional Feature:
- Macro: SIGNED_OVF_EN.
- Defined:
  - Port OVF is present.
  - On the final RUN beat, OVF<=(carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), using the slice's internal bit-0-to-bit-1 carry C1.
  - OVF is valid with O_VALID and resets to 0.
- Undefined: the OVF port and its flop are absent; C1 is left unconnected. All other behaviour is identical.

Decomposition:
- Package serial_add_pkg holds:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - constant SLICE_W=2.
  - function beats(WIDTH)=WIDTH/2, used to size the counter as clog2 of the beat count, minimum 1 bit.
- Sub-module add_slice2:
  - Purely combinational 2-bit ripple slice built from per-bit full-adder equations.
  - Inputs A[1:0], B[1:0], CI. Outputs S[1:0], CO, and C1 (internal carry).
  - Instantiated once.

Test Plan (WIDTH=8):
- 8'h5A+8'h3C, CIN=0, O_READY=1 -> O_VALID at t+5, O=8'h96, COUT=0, then I_READY=1 at t+6.
- 8'hFF+8'h01, CIN=0 -> O=8'h00, COUT=1, OVF=0. 8'hFF+8'hFF, CIN=1 -> O=8'hFF, COUT=1.
- 8'h7F+8'h01, CIN=0 -> O=8'h80, COUT=0, OVF=1 (with SIGNED_OVF_EN). 8'h80+8'h80 -> O=8'h00, COUT=1, OVF=1.
- Backpressure: O_READY=0 for 3 cycles in DONE -> O/COUT stable and I_READY=0 throughout; O_READY=1 -> IDLE next cycle.
- Change I0/I1 and pulse I_VALID during RUN -> ignored; result matches the latched operands. Back-to-back ops accepted at spacing 6.
- RESET during RUN beat 2 -> next cycle IDLE, O_VALID=0, O=0, COUT=0, no result. Then 8'h01+8'h01, CIN=1 -> O=8'h03.
